// File: rtl/rv32i_pkg.sv
// Shared constants and the IF/ID pipeline register type for the RV32I fetch stage.
package rv32i_pkg;
  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
  } if_id_t;

  function automatic if_id_t bubble(input logic [31:0] nop);
    if_id_t b;
    b.valid    = 1'b0;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.inst     = nop;
    return b;
  endfunction
endpackage

// File: rtl/rv32i_if_stage_if.sv
// Control bundle between the fetch stage and its PC register.
interface rv32i_if_stage_if #(parameter int W = 32);
  logic         stall;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic [W-1:0] pc;

  modport master (output stall, redirect_valid, redirect_pc, input pc);
  modport slave  (input stall, redirect_valid, redirect_pc, output pc);
endinterface

// File: rtl/rv32i_pc_reg.sv
// Program counter with next-PC selection: redirect > stall > sequential advance.
module rv32i_pc_reg
  import rv32i_pkg::*;
#(
  parameter int         W        = 32,
  parameter logic [W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  rv32i_if_stage_if.slave  ctl
);
  logic [W-1:0] pc_q, pc_d;

  // Redirect targets are forced word-aligned; misalignment is reported by the stage.
  always_comb begin
    pc_d = pc_q;
    if (ctl.redirect_valid) pc_d = {ctl.redirect_pc[W-1:2], 2'b00};
    else if (!ctl.stall)    pc_d = pc_q + W'(4);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) pc_q <= RESET_PC;
    else          pc_q <= pc_d;
  end

  assign ctl.pc = pc_q;
endmodule

// File: rtl/rv32i_if_stage.sv
// RV32I instruction fetch stage: PC register, combinational imem address, IF/ID register.
module rv32i_if_stage
  import rv32i_pkg::*;
#(
  parameter int                 INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = rv32i_pkg::NOP_INST
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic [INST_WIDTH-1:0] o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_redirect_valid,
  input  logic [INST_WIDTH-1:0] i_redirect_pc,
  output logic                  o_id_valid,
  output logic [INST_WIDTH-1:0] o_id_pc,
  output logic [INST_WIDTH-1:0] o_id_pc_plus4,
  output logic [INST_WIDTH-1:0] o_id_inst,
  output logic                  o_misalign
);
  rv32i_if_stage_if #(.W(INST_WIDTH)) ctl ();

  assign ctl.stall          = i_stall;
  assign ctl.redirect_valid = i_redirect_valid;
  assign ctl.redirect_pc    = i_redirect_pc;

  rv32i_pc_reg #(.W(INST_WIDTH), .RESET_PC(RESET_PC)) u_pc_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .ctl     (ctl.slave)
  );

  assign o_imem_addr = ctl.pc;

  if_id_t if_id_q, if_id_d;
  logic   misalign_q, misalign_d;

  // Flush and redirect both squash the word being fetched, even under stall.
  always_comb begin
    if_id_d = if_id_q;
    if (i_redirect_valid || i_flush) begin
      if_id_d = bubble(NOP_INST);
    end else if (!i_stall) begin
      if_id_d.valid    = 1'b1;
      if_id_d.pc       = ctl.pc;
      if_id_d.pc_plus4 = ctl.pc + INST_WIDTH'(4);
      if_id_d.inst     = i_imem_inst;
    end
    misalign_d = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      if_id_q    <= bubble(NOP_INST);
      misalign_q <= 1'b0;
    end else begin
      if_id_q    <= if_id_d;
      misalign_q <= misalign_d;
    end
  end

  assign o_id_valid    = if_id_q.valid;
  assign o_id_pc       = if_id_q.pc;
  assign o_id_pc_plus4 = if_id_q.pc_plus4;
  assign o_id_inst     = if_id_q.inst;
  assign o_misalign    = misalign_q;
endmodule

// File: tb/tb_rv32i_if_stage.sv
// Scoreboard bench for rv32i_if_stage: directed steps push expected post-edge state, a monitor compares.
module tb_rv32i_if_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_inst;
  logic        stall = 1'b0, flush = 1'b0, rv = 1'b0;
  logic [31:0] rpc = '0;
  logic        id_valid, misalign;
  logic [31:0] id_pc, id_pc4, id_inst;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        v;
    logic [31:0] pc, pc4, inst, addr;
    logic        mis;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Words 0..3 hold small markers; elsewhere a recognisable address-derived pattern.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction
  assign imem_inst = mem(imem_addr);

  rv32i_if_stage dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .o_imem_addr      (imem_addr),
    .i_imem_inst      (imem_inst),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_redirect_valid (rv),
    .i_redirect_pc    (rpc),
    .o_id_valid       (id_valid),
    .o_id_pc          (id_pc),
    .o_id_pc_plus4    (id_pc4),
    .o_id_inst        (id_inst),
    .o_misalign       (misalign)
  );

  task automatic chk(input string n, input int c, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", n, c, a, e);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("imem_addr", e.cyc, imem_addr, e.addr);
      chk("id_valid",  e.cyc, {31'b0, id_valid}, {31'b0, e.v});
      chk("id_pc",     e.cyc, id_pc, e.pc);
      chk("id_pc4",    e.cyc, id_pc4, e.pc4);
      chk("id_inst",   e.cyc, id_inst, e.inst);
      chk("misalign",  e.cyc, {31'b0, misalign}, {31'b0, e.mis});
    end
  end

  // Drive one cycle of inputs and record the state expected after the coming edge.
  task automatic step(input logic r, input logic s, input logic f, input logic v,
                      input logic [31:0] tgt, input logic [31:0] eaddr, input logic ev,
                      input logic [31:0] epc, input logic [31:0] epc4,
                      input logic [31:0] einst, input logic emis);
    exp_t e;
    @(posedge clk); #1;
    rst_n = r; stall = s; flush = f; rv = v; rpc = tgt;
    e.cyc = cyc + 1; e.addr = eaddr; e.v = ev; e.pc = epc; e.pc4 = epc4;
    e.inst = einst; e.mis = emis;
    q.push_back(e);
  endtask

  localparam logic [31:0] NOP = 32'h13;

  initial begin
    //    rst st fl rv target        addr          v  pc            pc4           inst          mis
    step(0, 0, 0, 0, 32'h0,         32'h0,        0, 32'h0,        32'h0,        NOP,          0);
    step(1, 0, 0, 0, 32'h0,         32'h4,        1, 32'h0,        32'h4,        32'h11,       0);
    step(1, 0, 0, 0, 32'h0,         32'h8,        1, 32'h4,        32'h8,        32'h22,       0);
    step(1, 1, 0, 0, 32'h0,         32'h8,        1, 32'h4,        32'h8,        32'h22,       0);
    step(1, 1, 0, 0, 32'h0,         32'h8,        1, 32'h4,        32'h8,        32'h22,       0);
    step(1, 1, 0, 0, 32'h0,         32'h8,        1, 32'h4,        32'h8,        32'h22,       0);
    step(1, 0, 0, 0, 32'h0,         32'hC,        1, 32'h8,        32'hC,        32'h33,       0);
    step(1, 0, 0, 0, 32'h0,         32'h10,       1, 32'hC,        32'h10,       32'h44,       0);
    // redirect to 0x40, then two sequential fetches from the target
    step(1, 0, 0, 1, 32'h40,        32'h40,       0, 32'h0,        32'h0,        NOP,          0);
    step(1, 0, 0, 0, 32'h0,         32'h44,       1, 32'h40,       32'h44,       32'hA5A50040, 0);
    step(1, 0, 0, 0, 32'h0,         32'h48,       1, 32'h44,       32'h48,       32'hA5A50044, 0);
    // misaligned redirect under stall: aligned PC, one-cycle flag
    step(1, 1, 0, 1, 32'h42,        32'h40,       0, 32'h0,        32'h0,        NOP,          1);
    step(1, 1, 0, 0, 32'h0,         32'h40,       0, 32'h0,        32'h0,        NOP,          0);
    step(1, 0, 0, 0, 32'h0,         32'h44,       1, 32'h40,       32'h44,       32'hA5A50040, 0);
    // flush with stall holds PC; flush alone advances PC
    step(1, 1, 1, 0, 32'h0,         32'h44,       0, 32'h0,        32'h0,        NOP,          0);
    step(1, 0, 1, 0, 32'h0,         32'h48,       0, 32'h0,        32'h0,        NOP,          0);
    step(1, 0, 0, 0, 32'h0,         32'h4C,       1, 32'h48,       32'h4C,       32'hA5A50048, 0);
    // back-to-back redirects: the latest wins
    step(1, 0, 0, 1, 32'h100,       32'h100,      0, 32'h0,        32'h0,        NOP,          0);
    step(1, 0, 0, 1, 32'h203,       32'h200,      0, 32'h0,        32'h0,        NOP,          1);
    step(1, 0, 0, 0, 32'h0,         32'h204,      1, 32'h200,      32'h204,      32'hA5A50200, 0);
    // wrap at top of address space
    step(1, 0, 0, 1, 32'hFFFFFFFC,  32'hFFFFFFFC, 0, 32'h0,        32'h0,        NOP,          0);
    step(1, 0, 0, 0, 32'h0,         32'h0,        1, 32'hFFFFFFFC, 32'h0,        32'h5A5AFFFC, 0);
    step(1, 0, 0, 0, 32'h0,         32'h4,        1, 32'h0,        32'h4,        32'h11,       0);
    // reset beats stall and a misaligned redirect in the same cycle
    step(0, 1, 0, 1, 32'h81,        32'h0,        0, 32'h0,        32'h0,        NOP,          0);
    step(1, 0, 0, 0, 32'h0,         32'h4,        1, 32'h0,        32'h4,        32'h11,       0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32i_if_stage.md
RV32I_IF_STAGE -- requirements
Module: rv32i_if_stage

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- INST_WIDTH, 32, instruction and address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- i_clk, in, 1, single clock; all state updates on rising edge.
- i_rst_n, in, 1, reset; synchronous and active-low.
- o_imem_addr, out, INST_WIDTH, byte address driven to the instruction memory (combinational read).
- i_imem_inst, in, INST_WIDTH, instruction returned by memory in the same cycle.
- i_stall, in, 1, hazard unit hold request.
- i_flush, in, 1, kill the instruction entering IF/ID.
- i_redirect_valid, in, 1, branch/jump taken.
- i_redirect_pc, in, INST_WIDTH, branch/jump target.
- o_id_valid, out, 1, IF/ID holds a real instruction.
- o_id_pc, out, INST_WIDTH, PC of the IF/ID instruction.
- o_id_pc_plus4, out, INST_WIDTH, o_id_pc+4 for JAL/JALR link.
- o_id_inst, out, INST_WIDTH, IF/ID instruction.
- o_misalign, out, 1, one-cycle pulse: last accepted redirect target had bits[1:0] != 0.

Function
REQ-003 o_imem_addr SHALL equal pc_q combinationally; no other logic in that path.
REQ-004 Fetch latency SHALL be 1 cycle: the word read at address A in cycle N appears on o_id_inst with o_id_pc=A in cycle N+1.
REQ-005 Priority per edge SHALL be: reset > redirect > stall > normal advance.
REQ-006 Normal advance (no stall, no redirect) SHALL set pc_q<=pc_q+4 and IF/ID<={valid=1, pc_q, pc_q+4, i_imem_inst}.
REQ-007 Stall without redirect SHALL hold pc_q and all IF/ID fields unchanged.
REQ-008 Redirect (stalled or not) SHALL set pc_q<={i_redirect_pc[31:2],2'b00}, and IF/ID SHALL be loaded as a bubble.
REQ-009 A bubble SHALL be: valid=0, inst=NOP_INST, pc and pc_plus4 = 0.
REQ-010 i_flush SHALL load a bubble into IF/ID even while i_stall=1; pc_q SHALL follow REQ-006/007/008 independently.
REQ-011 o_misalign SHALL be registered: 1 in the cycle after a redirect with i_redirect_pc[1:0]!=0, else 0.
REQ-012 PC arithmetic SHALL be modulo 2^32: pc_q=32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-013 Back-to-back redirects SHALL each take effect in the cycle they are presented; the last one wins.
REQ-014 o_id_pc_plus4 SHALL be registered, not recomputed from o_id_pc.

Reset
REQ-015 While i_rst_n=0 at an edge: pc_q=RESET_PC, o_id_valid=0, o_id_inst=NOP_INST, o_id_pc=0, o_id_pc_plus4=0, o_misalign=0.
REQ-016 In the first cycle after release, o_imem_addr SHALL equal RESET_PC and o_id_valid SHALL be 0.
REQ-017 Reset asserted mid-stall or concurrent with redirect SHALL override both.

Structure
REQ-018 rv32i_pkg SHALL hold NOP_INST, the RESET_PC default, and the if_id_t struct {valid, pc, pc_plus4, inst}; the IF/ID register SHALL be one if_id_t.
REQ-019 The PC register with its next-PC mux SHALL be sub-module rv32i_pc_reg; the IF/ID register stays in rv32i_if_stage.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset, memory words 0..3 = 0x11,0x22,0x33,0x44, 4 free cycles -> o_id_inst=0x11,0x22,0x33 with o_id_pc=0,4,8 and o_id_valid=1 from cycle 2.
- i_stall=1 for 3 cycles at pc_q=8 -> o_imem_addr stays 8; o_id_pc stays 4 with inst 0x22; resume yields 0x33.
- Redirect to 0x40 at pc_q=8 -> next cycle o_imem_addr=0x40 and IF/ID is a bubble (inst=0x13, valid=0); following cycle o_id_pc=0x40.
- Redirect to 0x42 while i_stall=1 -> pc_q=0x40, o_misalign=1 for exactly one cycle, IF/ID is a bubble.
- i_flush=1 and i_stall=1 together -> IF/ID is a bubble, pc_q held.
- pc_q forced to 0xFFFF_FFFC (redirect) -> next o_imem_addr=0; reset asserted mid-stream -> o_imem_addr=RESET_PC and valid=0 next cycle.
